// File: rtl/host_cmd_decoder.sv
`default_nettype none
// host_cmd_decoder: turns the host RX byte stream into state-code and program-image FIFO writes.
// Rev 1.0 - initial release.
module host_cmd_decoder #(
  parameter int MAX_LOAD       = 16384,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic        usb_clk,
  input  logic        usb_rst_n,
  input  logic        rx_fifo_empty,
  input  logic [7:0]  rx_fifo_out,
  output logic        rx_fifo_rd_en,
  input  logic        state_fifo_full,
  input  logic        state_fifo_wr_rst_busy,
  output logic [7:0]  state_fifo_in,
  output logic        state_fifo_wr_en,
  input  logic        mem_fifo_full,
  input  logic        mem_fifo_wr_rst_busy,
  output logic [7:0]  mem_fifo_in,
  output logic        mem_fifo_wr_en,
  output logic        load_active,
  output logic [15:0] bytes_remaining,
  output logic [7:0]  err_count,
  output logic        oversize_load
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STATE_ARG = 3'd1,
    S_LEN_LO    = 3'd2,
    S_LEN_HI    = 3'd3,
    S_PAYLOAD   = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] C_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     C_MAX_LEN  = 17'(MAX_LOAD);

  state_t          state_q, state_d;
  logic            gap_q, gap_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            rd_en_q, rd_en_d;
  logic            st_wr_q, st_wr_d;
  logic [7:0]      st_data_q, st_data_d;
  logic            mem_wr_q, mem_wr_d;
  logic [7:0]      mem_data_q, mem_data_d;
  logic            load_q, load_d;
  logic [15:0]     rem_q, rem_d;
  logic [7:0]      err_q, err_d;
  logic            ovs_q, ovs_d;

  logic            w_state_ok;
  logic            w_mem_ok;
  logic            w_valid_arg;
  logic            w_err_inc;
  logic [15:0]     w_len;

  always_comb begin
    state_d    = state_q;
    gap_d      = 1'b0;
    to_d       = to_q;
    rd_en_d    = 1'b0;
    st_wr_d    = 1'b0;
    st_data_d  = st_data_q;
    mem_wr_d   = 1'b0;
    mem_data_d = mem_data_q;
    rem_d      = rem_q;
    ovs_d      = ovs_q;
    w_err_inc  = 1'b0;
    w_state_ok  = !state_fifo_full && !state_fifo_wr_rst_busy;
    w_mem_ok    = !mem_fifo_full && !mem_fifo_wr_rst_busy;
    w_valid_arg = (rx_fifo_out == 8'h01) || (rx_fifo_out == 8'h02) || (rx_fifo_out == 8'h04);
    w_len       = {rx_fifo_out, rem_q[7:0]};

    // The cycle after any pop is a dead cycle so the flags seen here are never stale.
    if (!gap_q && !rx_fifo_empty) begin
      case (state_q)
        S_IDLE: begin
          rd_en_d = 1'b1;
          case (rx_fifo_out)
            8'h00:   state_d = S_IDLE;
            8'h01:   state_d = S_STATE_ARG;
            8'h02:   state_d = S_LEN_LO;
            default: w_err_inc = 1'b1;
          endcase
        end
        S_STATE_ARG: begin
          if (!w_valid_arg) begin
            rd_en_d   = 1'b1;
            w_err_inc = 1'b1;
            state_d   = S_IDLE;
          end else if (w_state_ok) begin
            rd_en_d   = 1'b1;
            st_wr_d   = 1'b1;
            st_data_d = rx_fifo_out;
            state_d   = S_IDLE;
          end
        end
        S_LEN_LO: begin
          rd_en_d = 1'b1;
          rem_d   = {8'h00, rx_fifo_out};
          state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          rd_en_d = 1'b1;
          rem_d   = w_len;
          state_d = (w_len == 16'd0) ? S_IDLE : S_PAYLOAD;
          if ({1'b0, w_len} > C_MAX_LEN) begin
            ovs_d = 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (w_mem_ok) begin
            rd_en_d    = 1'b1;
            mem_wr_d   = 1'b1;
            mem_data_d = rx_fifo_out;
            rem_d      = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A byte present on the expiry edge keeps rx_fifo_empty low, so it always wins.
    if (rd_en_d || (state_q == S_IDLE)) begin
      to_d = '0;
    end else if (rx_fifo_empty) begin
      if (to_q == C_TO_LAST) begin
        to_d      = '0;
        w_err_inc = 1'b1;
        rem_d     = 16'd0;
        state_d   = S_IDLE;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end

    gap_d  = rd_en_d;
    load_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_PAYLOAD);
    err_d  = (w_err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge usb_clk) begin
    if (!usb_rst_n) begin
      state_q    <= S_IDLE;
      gap_q      <= 1'b0;
      to_q       <= '0;
      rd_en_q    <= 1'b0;
      st_wr_q    <= 1'b0;
      st_data_q  <= 8'h00;
      mem_wr_q   <= 1'b0;
      mem_data_q <= 8'h00;
      load_q     <= 1'b0;
      rem_q      <= 16'd0;
      err_q      <= 8'h00;
      ovs_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      to_q       <= to_d;
      rd_en_q    <= rd_en_d;
      st_wr_q    <= st_wr_d;
      st_data_q  <= st_data_d;
      mem_wr_q   <= mem_wr_d;
      mem_data_q <= mem_data_d;
      load_q     <= load_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      ovs_q      <= ovs_d;
    end
  end

  assign rx_fifo_rd_en    = rd_en_q;
  assign state_fifo_wr_en = st_wr_q;
  assign state_fifo_in    = st_data_q;
  assign mem_fifo_wr_en   = mem_wr_q;
  assign mem_fifo_in      = mem_data_q;
  assign load_active      = load_q;
  assign bytes_remaining  = rem_q;
  assign err_count        = err_q;
  assign oversize_load    = ovs_q;

endmodule
`default_nettype wire

// File: tb/tb_host_cmd_decoder.sv
`default_nettype none
// Bench for host_cmd_decoder: command vector table with a write scoreboard,
// plus stall, timeout, saturation and mid-load reset sequences.
module tb_host_cmd_decoder;
  localparam int MAX_LOAD       = 8;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int TO_W           = 20;
  localparam int NVEC           = 11;

  logic        usb_clk = 1'b0;
  logic        usb_rst_n;
  logic        rx_fifo_empty;
  logic [7:0]  rx_fifo_out;
  logic        rx_fifo_rd_en;
  logic        state_fifo_full;
  logic        state_fifo_wr_rst_busy;
  logic [7:0]  state_fifo_in;
  logic        state_fifo_wr_en;
  logic        mem_fifo_full;
  logic        mem_fifo_wr_rst_busy;
  logic [7:0]  mem_fifo_in;
  logic        mem_fifo_wr_en;
  logic        load_active;
  logic [15:0] bytes_remaining;
  logic [7:0]  err_count;
  logic        oversize_load;

  host_cmd_decoder #(
    .MAX_LOAD(MAX_LOAD), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)
  ) dut (
    .usb_clk(usb_clk), .usb_rst_n(usb_rst_n),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_out(rx_fifo_out), .rx_fifo_rd_en(rx_fifo_rd_en),
    .state_fifo_full(state_fifo_full), .state_fifo_wr_rst_busy(state_fifo_wr_rst_busy),
    .state_fifo_in(state_fifo_in), .state_fifo_wr_en(state_fifo_wr_en),
    .mem_fifo_full(mem_fifo_full), .mem_fifo_wr_rst_busy(mem_fifo_wr_rst_busy),
    .mem_fifo_in(mem_fifo_in), .mem_fifo_wr_en(mem_fifo_wr_en),
    .load_active(load_active), .bytes_remaining(bytes_remaining),
    .err_count(err_count), .oversize_load(oversize_load)
  );

  always #5 usb_clk = ~usb_clk;

  // Byte i of a field lives at [8*i +: 8].
  typedef struct {
    int          n;
    logic [127:0] bytes;
    bit          st_wr;
    logic [7:0]  st;
    int          nm;
    logic [127:0] mem;
    int          err;
    bit          ovs;
  } vec_t;

  vec_t       vecs[NVEC];
  logic [7:0] rx_q[$];
  logic [7:0] exp_st_q[$];
  logic [7:0] exp_mem_q[$];
  int         checks   = 0;
  int         failures = 0;
  bit         rd_prev  = 1'b0;
  bit         chk_rem  = 1'b1;
  int         idle_cnt = 0;
  int         exp_err  = 0;
  bit         exp_ovs  = 1'b0;

  task automatic set_vec(input int idx, input int n, input logic [127:0] b, input bit sw,
                         input logic [7:0] st, input int nm, input logic [127:0] m,
                         input int err, input bit ovs);
    vecs[idx].n = n; vecs[idx].bytes = b; vecs[idx].st_wr = sw; vecs[idx].st = st;
    vecs[idx].nm = nm; vecs[idx].mem = m; vecs[idx].err = err; vecs[idx].ovs = ovs;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh_rx();
    rx_fifo_empty = (rx_q.size() == 0);
    rx_fifo_out   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_q.push_back(b);
    refresh_rx();
  endtask

  // One clock: FWFT pop on a registered rd_en, then scoreboard any write strobes.
  task automatic step();
    logic       pre_empty, pre_sblk, pre_mblk;
    logic [7:0] e;
    pre_empty = rx_fifo_empty;
    pre_sblk  = state_fifo_full | state_fifo_wr_rst_busy;
    pre_mblk  = mem_fifo_full | mem_fifo_wr_rst_busy;
    @(posedge usb_clk);
    #1;
    if (pre_empty) idle_cnt++; else idle_cnt = 0;
    if (rd_prev && rx_q.size() > 0) void'(rx_q.pop_front());
    refresh_rx();
    if (rx_fifo_rd_en === 1'b1) begin
      checks++;
      if (rd_prev || pre_empty) begin
        failures++;
        $display("FAIL rd_en_legal: back_to_back=%0d empty_at_edge=%0d, required 0 and 0", rd_prev, pre_empty);
      end
    end
    rd_prev = (rx_fifo_rd_en === 1'b1);
    if (state_fifo_wr_en === 1'b1) begin
      if (exp_st_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL state_wr: unexpected write of 0x%0h, required no write", state_fifo_in);
      end else begin
        e = exp_st_q.pop_front();
        check("state_wr_data", 32'(state_fifo_in), 32'(e));
        check("state_wr_while_blocked", 32'(pre_sblk), 32'd0);
      end
    end
    if (mem_fifo_wr_en === 1'b1) begin
      if (exp_mem_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL mem_wr: unexpected write of 0x%0h, required no write", mem_fifo_in);
      end else begin
        e = exp_mem_q.pop_front();
        check("mem_wr_data", 32'(mem_fifo_in), 32'(e));
        check("mem_wr_while_blocked", 32'(pre_mblk), 32'd0);
        if (chk_rem) check("bytes_remaining_track", 32'(bytes_remaining), 32'(exp_mem_q.size()));
      end
    end
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while (rx_q.size() != 0 && k < bound) begin
      step();
      k++;
    end
    check("drain_bytes_left", 32'(rx_q.size()), 32'd0);
    repeat (4) step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int pops;
    usb_rst_n = 1'b0;
    state_fifo_full = 1'b0; state_fifo_wr_rst_busy = 1'b0;
    mem_fifo_full = 1'b0;   mem_fifo_wr_rst_busy = 1'b0;
    refresh_rx();

    set_vec(0,  2, 128'h0201,                         1, 8'h02, 0, 128'h0, 0, 0);
    set_vec(1,  7, 128'hDDCCBBAA000402,               0, 8'h00, 4, 128'hDDCCBBAA, 0, 0);
    set_vec(2,  3, 128'h070301,                       0, 8'h00, 0, 128'h0, 2, 0);
    set_vec(3,  3, 128'h040100,                       1, 8'h04, 0, 128'h0, 0, 0);
    set_vec(4,  2, 128'h0101,                         1, 8'h01, 0, 128'h0, 0, 0);
    set_vec(5,  3, 128'h000002,                       0, 8'h00, 0, 128'h0, 0, 0);
    set_vec(6,  4, 128'h5A000102,                     0, 8'h00, 1, 128'h5A, 0, 0);
    set_vec(7, 11, 128'h8877665544332211000802,       0, 8'h00, 8, 128'h8877665544332211, 0, 0);
    set_vec(8, 12, 128'h090807060504030201000902,     0, 8'h00, 9, 128'h090807060504030201, 0, 1);
    set_vec(9,  5, 128'h0201000202,                   0, 8'h00, 2, 128'h0201, 0, 0);
    set_vec(10, 2, 128'h0801,                         0, 8'h00, 0, 128'h0, 1, 0);

    repeat (3) step();
    check("reset_strobes", {29'd0, rx_fifo_rd_en, state_fifo_wr_en, mem_fifo_wr_en}, 32'd0);
    check("reset_data", {16'd0, state_fifo_in, mem_fifo_in}, 32'd0);
    check("reset_status", {6'd0, load_active, oversize_load, err_count, bytes_remaining}, 32'd0);
    usb_rst_n = 1'b1;
    step();

    for (int v = 0; v < NVEC; v++) begin
      for (int i = 0; i < vecs[v].n; i++) push_byte(vecs[v].bytes[8*i +: 8]);
      if (vecs[v].st_wr) exp_st_q.push_back(vecs[v].st);
      for (int i = 0; i < vecs[v].nm; i++) exp_mem_q.push_back(vecs[v].mem[8*i +: 8]);
      exp_err += vecs[v].err;
      if (vecs[v].ovs) exp_ovs = 1'b1;
      drain(200);
      check("err_count", 32'(err_count), 32'(exp_err));
      check("oversize_load", 32'(oversize_load), 32'(exp_ovs));
      check("state_writes_pending", 32'(exp_st_q.size()), 32'd0);
      check("mem_writes_pending", 32'(exp_mem_q.size()), 32'd0);
      check("load_active_after", 32'(load_active), 32'd0);
      check("bytes_remaining_after", 32'(bytes_remaining), 32'd0);
    end

    // Mem FIFO goes full right after the first payload byte of a 3-byte load.
    push_byte(8'h02); push_byte(8'h03); push_byte(8'h00);
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    exp_mem_q.push_back(8'hA1); exp_mem_q.push_back(8'hB2); exp_mem_q.push_back(8'hC3);
    k = 0;
    while (mem_fifo_wr_en !== 1'b1 && k < 100) begin step(); k++; end
    check("stall_first_write", 32'(mem_fifo_wr_en), 32'd1);
    mem_fifo_full = 1'b1;
    pops = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (rx_fifo_rd_en === 1'b1) pops++;
    end
    check("stall_no_pop", 32'(pops), 32'd0);
    check("stall_bytes_held", 32'(rx_q.size()), 32'd2);
    check("stall_load_active", 32'(load_active), 32'd1);
    check("stall_bytes_remaining", 32'(bytes_remaining), 32'd2);
    mem_fifo_full = 1'b0;
    drain(100);
    check("stall_mem_pending", 32'(exp_mem_q.size()), 32'd0);
    check("stall_err_count", 32'(err_count), 32'(exp_err));

    // LEN=16 but only 5 bytes arrive; the untargeted state FIFO is full throughout.
    chk_rem = 1'b0;
    state_fifo_full = 1'b1;
    push_byte(8'h02); push_byte(8'h10); push_byte(8'h00);
    for (int i = 0; i < 5; i++) begin
      push_byte(8'hE0 + 8'(i));
      exp_mem_q.push_back(8'hE0 + 8'(i));
    end
    k = 0;
    while (err_count === 8'(exp_err) && k < 400) begin step(); k++; end
    exp_err++;
    check("timeout_err_count", 32'(err_count), 32'(exp_err));
    check("timeout_idle_clocks", 32'(idle_cnt), 32'(TIMEOUT_CYCLES));
    check("timeout_bytes_remaining", 32'(bytes_remaining), 32'd0);
    check("timeout_load_active", 32'(load_active), 32'd0);
    check("timeout_mem_pending", 32'(exp_mem_q.size()), 32'd0);
    state_fifo_full = 1'b0;
    chk_rem = 1'b1;
    push_byte(8'h01); push_byte(8'h04);
    exp_st_q.push_back(8'h04);
    drain(50);
    check("post_timeout_state_pending", 32'(exp_st_q.size()), 32'd0);
    check("post_timeout_err_count", 32'(err_count), 32'(exp_err));

    // err_count must saturate.
    for (int i = 0; i < 300; i++) push_byte(8'hFF);
    drain(1000);
    check("err_saturated", 32'(err_count), 32'd255);

    // Reset in the middle of a load.
    chk_rem = 1'b0;
    push_byte(8'h02); push_byte(8'h08); push_byte(8'h00);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    exp_mem_q.push_back(8'h11); exp_mem_q.push_back(8'h22); exp_mem_q.push_back(8'h33);
    k = 0;
    while (exp_mem_q.size() > 1 && k < 100) begin step(); k++; end
    check("pre_reset_writes", 32'(exp_mem_q.size()), 32'd1);
    usb_rst_n = 1'b0;
    step();
    check("midrst_strobes", {29'd0, rx_fifo_rd_en, state_fifo_wr_en, mem_fifo_wr_en}, 32'd0);
    check("midrst_data", {16'd0, state_fifo_in, mem_fifo_in}, 32'd0);
    check("midrst_status", {6'd0, load_active, oversize_load, err_count, bytes_remaining}, 32'd0);
    rx_q.delete();
    exp_mem_q.delete();
    refresh_rx();
    rd_prev = 1'b0;
    step();
    usb_rst_n = 1'b1;
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_fifo_wr_en === 1'b1) pops++;
    end
    check("post_reset_no_mem_write", 32'(pops), 32'd0);
    check("post_reset_err_count", 32'(err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/host_cmd_decoder.md
Name: host_cmd_decoder

Overview:
- Decodes the host USB byte stream into the two command FIFOs consumed by the core-control stage.
- Reads the host RX FIFO (first-word-fall-through) and writes the state FIFO (one-hot PICORV state codes) and the mem FIFO (program image bytes).
- Runs entirely in the USB clock domain. The FIFOs provide the crossing to the core clock.

Parameters:
- MAX_LOAD, 16384, largest legal LOAD length in bytes (main-memory size). Longer loads are still forwarded but flagged.
- TIMEOUT_CYCLES, 1000000, idle clocks allowed mid-command before abort.
- TO_W, 20, width of the timeout counter.

Ports:
- usb_clk  in  1  block clock
- usb_rst_n  in  1  synchronous active-low reset
- rx_fifo_empty  in  1  host RX FIFO empty
- rx_fifo_out  in  8  host RX FIFO head byte (FWFT)
- rx_fifo_rd_en  out  1  pop RX head
- state_fifo_full  in  1  state FIFO full
- state_fifo_wr_rst_busy  in  1  state FIFO write side in reset
- state_fifo_in  out  8  state code to write
- state_fifo_wr_en  out  1  state FIFO write strobe
- mem_fifo_full  in  1  mem FIFO full
- mem_fifo_wr_rst_busy  in  1  mem FIFO write side in reset
- mem_fifo_in  out  8  image byte to write
- mem_fifo_wr_en  out  1  mem FIFO write strobe
- load_active  out  1  high while in LEN_LO/LEN_HI/PAYLOAD
- bytes_remaining  out  16  payload bytes still expected
- err_count  out  8  saturating protocol-error counter
- oversize_load  out  1  sticky: a LEN > MAX_LOAD was accepted

Behaviour:
- Reset (sync, usb_rst_n=0 at posedge):
  - All strobes = 0; state_fifo_in = mem_fifo_in = 0.
  - bytes_remaining = 0, err_count = 0, oversize_load = 0, load_active = 0.
  - FSM = IDLE; timeout counter = 0.
  - Reset mid-command abandons it silently. No partial write is issued after reset.
- All outputs are registered.
- Step rule (one byte per two clocks max):
  - At a decision edge the FSM may register rx_fifo_rd_en=1, plus at most one write strobe with its data.
  - Strobes are high for exactly the following cycle. That following cycle is a mandatory gap with no decision.
  - Full/busy flags sampled at a decision edge are therefore never stale.
- A byte is consumed only if rx_fifo_empty=0 and, when it produces a write, the target FIFO has full=0 and wr_rst_busy=0.
  - Otherwise nothing is popped and the FSM stalls. Stall cycles are not errors.
- FSM states:
  - IDLE:
    - 0x01 -> STATE_ARG.
    - 0x02 -> LEN_LO.
    - 0x00 (NOP) -> stay in IDLE.
    - Any other byte: pop it, err_count+1, stay in IDLE.
  - STATE_ARG: byte in {0x01,0x02,0x04} -> write it to the state FIFO (pop and write in the same step), then IDLE. Any other byte: pop it, err_count+1, no write, then IDLE.
  - LEN_LO: pop; latch bytes_remaining[7:0]; -> LEN_HI.
  - LEN_HI: pop; latch bytes_remaining[15:8].
    - Full 16-bit value LEN = 0 -> IDLE.
    - Otherwise -> PAYLOAD.
    - LEN > MAX_LOAD sets oversize_load.
  - PAYLOAD: each step pops one byte, writes it to the mem FIFO and decrements bytes_remaining. The step that reaches 0 returns to IDLE. Payload byte values are never interpreted.
- Timeout:
  - The counter runs in STATE_ARG/LEN_LO/LEN_HI/PAYLOAD while rx_fifo_empty=1. It clears on any pop and in IDLE.
  - It does not advance while stalled on a full target.
  - Reaching TIMEOUT_CYCLES -> err_count+1, bytes_remaining=0, FSM=IDLE. Bytes already forwarded stay forwarded.
- err_count saturates at 255 and never wraps.
- Simultaneous events:
  - Timeout expiry and byte arrival on the same edge: the byte wins and the timeout clears.
  - Both target FIFOs full: only the FIFO the current state targets matters.

Test Plan:
- Bytes 01 02 with both FIFOs empty -> one state_fifo_wr_en pulse with state_fifo_in=0x02. No mem write, err_count=0, FSM back to IDLE. The two rx_fifo_rd_en pulses are at least 2 clocks apart.
- Bytes 02 04 00 AA BB CC DD -> mem_fifo_in sequence AA,BB,CC,DD with 4 wr_en pulses. bytes_remaining goes 4,3,2,1,0. load_active drops after DD. oversize_load stays 0.
- Bytes 01 03 then 07 -> two errors: 03 is a bad state arg, 07 is a bad opcode. err_count=2 and no state write.
- LOAD of length 3 with mem_fifo_full held high for 50 clocks after the first byte -> no pop during the stall, and the 2nd and 3rd bytes are written once full drops. No error.
- Bytes 02 10 00 then 5 payload bytes then silence, with TIMEOUT_CYCLES=100 -> abort exactly 100 idle clocks after the last pop. err_count=1, bytes_remaining=0, and a following 01 04 is honoured.
- 300 bytes of 0xFF -> err_count=255, no wrap. Assert usb_rst_n=0 mid-LOAD -> all outputs zero on the next edge and no further mem writes.
